ram_frame_ctrl: RTL and testbench

RAM_FRAME_CTRL -- requirements
Module: ram_frame_ctrl

---
 rtl/ram_frame_ctrl_if.sv | 30 +++
 rtl/ram_frame_ctrl.sv | 87 ++++++++
 tb/tb_ram_frame_ctrl.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/ram_frame_ctrl_if.sv
// Handshake and RAM-port bundle for ram_frame_ctrl; master is the controller side,
// slave is the surrounding logic (upstream source, RAM, downstream sink).
interface ram_frame_ctrl_if #(
  parameter int DW = 8,
  parameter int AW = 7
);
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_last;
  logic          in_ready;
  logic [AW-1:0] mem_a;
  logic [DW-1:0] mem_d;
  logic          mem_we;
  logic [DW-1:0] mem_q;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_last;
  logic          out_ready;
  logic [7:0]    frame_cnt;

  modport master (
    input  in_data, in_valid, in_last, mem_q, out_ready,
    output in_ready, mem_a, mem_d, mem_we, out_data, out_valid, out_last, frame_cnt
  );

  modport slave (
    output in_data, in_valid, in_last, mem_q, out_ready,
    input  in_ready, mem_a, mem_d, mem_we, out_data, out_valid, out_last, frame_cnt
  );
endinterface

// File: rtl/ram_frame_ctrl.sv
// Single-frame store-and-forward buffer over an external RAM: FILL writes a frame, DRAIN replays it.
// First out beat 1 cycle after DRAIN entry, then 1/cycle; out stalls on !out_ready, in_ready low while draining.
module ram_frame_ctrl #(
  parameter int DW = 8,
  parameter int AW = 7
) (
  input  logic              clk,
  input  logic              rst,
  ram_frame_ctrl_if.master  bus
);
  // len value at which one more accepted beat fills the buffer
  localparam logic [AW:0] LEN_LAST = (AW+1)'((1 << AW) - 1);

  typedef enum logic {FILL, DRAIN} state_t;

  state_t        state;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   len;
  logic [AW:0]   rd_cnt;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_last;
  logic [7:0]    frame_cnt;
  logic          load;
  logic          done;

  always_comb begin
    load = (state == DRAIN) && (!out_valid || bus.out_ready) && (rd_cnt < len);
    done = (state == DRAIN) && out_valid && bus.out_ready && out_last;
  end

  assign bus.in_ready  = (state == FILL) && !rst;
  assign bus.mem_we    = (state == FILL) && bus.in_valid && !rst;
  assign bus.mem_a     = (state == FILL) ? wr_ptr : rd_ptr;
  assign bus.mem_d     = bus.in_data;
  assign bus.out_data  = out_data;
  assign bus.out_valid = out_valid;
  assign bus.out_last  = out_last;
  assign bus.frame_cnt = frame_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= FILL;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      rd_cnt    <= '0;
      len       <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      frame_cnt <= '0;
    end else begin
      case (state)
        FILL: begin
          if (bus.in_valid) begin
            wr_ptr <= wr_ptr + 1'b1;
            len    <= len + 1'b1;
            if (bus.in_last || len == LEN_LAST) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (done) begin
            state     <= FILL;
            frame_cnt <= frame_cnt + 1'b1;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            rd_cnt    <= '0;
            len       <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
          end else if (load) begin
            out_data  <= bus.mem_q;
            out_valid <= 1'b1;
            out_last  <= (rd_cnt == len - 1'b1);
            rd_ptr    <= rd_ptr + 1'b1;
            rd_cnt    <= rd_cnt + 1'b1;
          end else if (out_valid && bus.out_ready) begin
            // accepted beat with nothing left to load behind it
            out_valid <= 1'b0;
            out_last  <= 1'b0;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_ram_frame_ctrl.sv
// Directed bench for ram_frame_ctrl: cycle-exact vector table plus frame-level sequences.
module tb_ram_frame_ctrl;
  localparam int DW = 8;
  localparam int AW = 7;
  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  ram_frame_ctrl_if #(.DW(DW), .AW(AW)) bus ();

  ram_frame_ctrl #(.DW(DW), .AW(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // behavioural RAM: synchronous write, combinational read
  logic [DW-1:0] ram [1 << AW];
  always @(posedge clk) if (bus.mem_we) ram[bus.mem_a] <= bus.mem_d;
  assign bus.mem_q = ram[bus.mem_a];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic       rst;
    logic       iv;
    logic [7:0] id;
    logic       il;
    logic       ordy;
    logic       ir;
    logic       we;
    logic [6:0] a;
    logic       ov;
    logic [7:0] od;
    logic       ol;
    logic [7:0] fc;
    logic       chk_od;
  } vec_t;

  vec_t vt [13];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic send_frame(input int n, input logic [7:0] base, input logic with_last);
    for (int i = 0; i < n; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = base + 8'(i);
      bus.in_last  = with_last && (i == n - 1);
      #1;
      chk("fill_rdy_we", 32'({bus.in_ready, bus.mem_we}), 32'h3);
      chk("fill_addr", 32'(bus.mem_a), 32'(i));
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    #1;
    chk("drain_entry_in_ready", 32'(bus.in_ready), 32'h0);
    chk("drain_entry_out_valid", 32'(bus.out_valid), 32'h0);
  endtask

  // call at negedge+1 of the DRAIN entry cycle; returns at negedge+1 after the last handshake
  task automatic drain(input int n, input logic [7:0] base, input logic [7:0] exp_fc);
    int got;
    int cyc;
    got = 0;
    cyc = 0;
    bus.out_ready = 1'b1;
    while (got < n && cyc < n + 10) begin
      if (bus.out_valid) begin
        chk("drain_data", 32'(bus.out_data), 32'(base + 8'(got)));
        chk("drain_last", 32'(bus.out_last), 32'(got == n - 1));
        got++;
      end
      @(negedge clk);
      #1;
      cyc++;
    end
    chk("drain_count", 32'(got), 32'(n));
    chk("post_drain_in_ready", 32'(bus.in_ready), 32'h1);
    chk("post_drain_frame_cnt", 32'(bus.frame_cnt), 32'(exp_fc));
  endtask

  initial begin
    logic [26:0] act;
    logic [26:0] exp;
    int got;
    int cyc;
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;

    //         rst iv  id     il ordy | ir we a      ov od     ol fc    chk_od
    vt[0]  = '{H, H, 8'h5A, L, H,     L, L, 7'd0, L, 8'h00, L, 8'd0, H};
    vt[1]  = '{L, H, 8'h11, L, H,     H, H, 7'd0, L, 8'h00, L, 8'd0, H};
    vt[2]  = '{L, H, 8'h22, L, H,     H, H, 7'd1, L, 8'h00, L, 8'd0, L};
    vt[3]  = '{L, H, 8'h33, L, H,     H, H, 7'd2, L, 8'h00, L, 8'd0, L};
    vt[4]  = '{L, H, 8'h44, H, H,     H, H, 7'd3, L, 8'h00, L, 8'd0, L};
    vt[5]  = '{L, L, 8'h00, L, H,     L, L, 7'd0, L, 8'h00, L, 8'd0, L};
    vt[6]  = '{L, L, 8'h00, L, H,     L, L, 7'd1, H, 8'h11, L, 8'd0, H};
    vt[7]  = '{L, L, 8'h00, L, L,     L, L, 7'd2, H, 8'h22, L, 8'd0, H};
    vt[8]  = '{L, L, 8'h00, L, L,     L, L, 7'd2, H, 8'h22, L, 8'd0, H};
    vt[9]  = '{L, L, 8'h00, L, H,     L, L, 7'd2, H, 8'h22, L, 8'd0, H};
    vt[10] = '{L, L, 8'h00, L, H,     L, L, 7'd3, H, 8'h33, L, 8'd0, H};
    vt[11] = '{L, L, 8'h00, L, H,     L, L, 7'd4, H, 8'h44, H, 8'd0, H};
    vt[12] = '{L, L, 8'h00, L, H,     H, L, 7'd0, L, 8'h00, L, 8'd1, L};

    @(negedge clk);
    @(negedge clk);

    // 4-byte frame with a 1,0,0,1 out_ready pattern during DRAIN
    for (int i = 0; i < 13; i++) begin
      rst           = vt[i].rst;
      bus.in_valid  = vt[i].iv;
      bus.in_data   = vt[i].id;
      bus.in_last   = vt[i].il;
      bus.out_ready = vt[i].ordy;
      #1;
      act = {bus.in_ready, bus.mem_we, bus.mem_a, bus.out_valid,
             vt[i].chk_od ? bus.out_data : 8'h00, bus.out_last, bus.frame_cnt};
      exp = {vt[i].ir, vt[i].we, vt[i].a, vt[i].ov, vt[i].od, vt[i].ol, vt[i].fc};
      chk($sformatf("vec%0d", i), 32'(act), 32'(exp));
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;

    // single-beat frame: out beat exactly one cycle after DRAIN entry
    bus.out_ready = 1'b1;
    send_frame(1, 8'hA5, 1'b1);
    @(negedge clk);
    #1;
    chk("a5_valid", 32'(bus.out_valid), 32'h1);
    chk("a5_data", 32'(bus.out_data), 32'hA5);
    chk("a5_last", 32'(bus.out_last), 32'h1);
    @(negedge clk);
    #1;
    chk("a5_in_ready", 32'(bus.in_ready), 32'h1);
    chk("a5_frame_cnt", 32'(bus.frame_cnt), 32'd2);
    chk("a5_out_valid_clear", 32'(bus.out_valid), 32'h0);

    // full buffer with no in_last: DRAIN forced by capacity
    send_frame(128, 8'h00, 1'b0);
    drain(128, 8'h00, 8'd3);

    // reset after 3 of 5 bytes drained discards the frame
    send_frame(5, 8'hD0, 1'b1);
    got = 0;
    cyc = 0;
    while (got < 3 && cyc < 20) begin
      if (bus.out_valid) begin
        chk("part_data", 32'(bus.out_data), 32'(8'hD0 + 8'(got)));
        got++;
      end
      @(negedge clk);
      #1;
      cyc++;
    end
    chk("part_count", 32'(got), 32'd3);
    rst = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'hEE;
    bus.out_ready = 1'b0;
    #1;
    chk("rst_rdy_we", 32'({bus.in_ready, bus.mem_we}), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
    chk("rst_frame_cnt", 32'(bus.frame_cnt), 32'h0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'h1);
    send_frame(2, 8'hC0, 1'b1);
    drain(2, 8'hC0, 8'd1);

    // frame counter wrap using 1-byte frames
    for (int f = 0; f < 254; f++) begin
      send_frame(1, 8'(f), 1'b1);
      drain(1, 8'(f), 8'(f + 2));
    end
    chk("fc_255", 32'(bus.frame_cnt), 32'd255);
    send_frame(1, 8'h77, 1'b1);
    drain(1, 8'h77, 8'd0);
    chk("fc_wrap", 32'(bus.frame_cnt), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
